// File: rtl/vram_dma.sv
// vram_dma: copies 32-bit words from main memory into VRAM32.
// The CPU programs SRC/DST/LEN, then starts a copy either immediately or on
// the next frame-drawn interrupt so updates can land in vertical blanking.
module vram_dma #(
    parameter int unsigned ADDR_W = 27,
    parameter int unsigned VRAM_W = 14
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_addr,
    input  logic [31:0]       cfg_data,
    input  logic              frameDrawn,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_q,
    output logic              vram32_we,
    output logic [VRAM_W-1:0] vram32_waddr,
    output logic [31:0]       vram32_d,
    output logic              busy,
    output logic [VRAM_W-1:0] remaining,
    output logic              done_irq
);

    typedef enum logic [2:0] {
        StIdle,
        StWaitFrame,
        StRead,
        StWrite,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Programmed registers and working copies
    logic [ADDR_W-1:0] src_q, src_ptr_q;
    logic [VRAM_W-1:0] dst_q, dst_ptr_q;
    logic [VRAM_W-1:0] len_q, remaining_q;
    logic [31:0]       data_q;
    logic              abort_q, abort_d;

    // Frame interrupt crossing: two sync flops, one history flop, registered edge
    logic fd_s1_q, fd_s2_q, fd_s3_q, frame_evt_q;

    logic cfg_ctrl, ctrl_start, ctrl_sync, ctrl_abort;
    logic unused_cfg;

    assign cfg_ctrl   = cfg_we && (cfg_addr == 2'd3);
    assign ctrl_start = cfg_ctrl && cfg_data[0];
    assign ctrl_sync  = cfg_data[1];
    assign ctrl_abort = cfg_ctrl && cfg_data[2];
    assign unused_cfg = ^cfg_data;

    // Synchronize frameDrawn into clk and turn its rising edge into a one-cycle event
    always_ff @(posedge clk) begin
        if (!nreset) begin
            fd_s1_q     <= 1'b0;
            fd_s2_q     <= 1'b0;
            fd_s3_q     <= 1'b0;
            frame_evt_q <= 1'b0;
        end else begin
            fd_s1_q     <= frameDrawn;
            fd_s2_q     <= fd_s1_q;
            fd_s3_q     <= fd_s2_q;
            frame_evt_q <= fd_s2_q & ~fd_s3_q;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort in READ is remembered until the pending ack returns
    always_comb begin
        state_d = state_q;
        abort_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ctrl_start) begin
                    if (ctrl_sync) begin
                        state_d = StWaitFrame;
                    end else if (len_q == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StWaitFrame: begin
                if (ctrl_abort) begin
                    state_d = StIdle;
                end else if (frame_evt_q) begin
                    state_d = (remaining_q == '0) ? StDone : StRead;
                end
            end
            StRead: begin
                abort_d = (abort_q || ctrl_abort) && !mem_ack;
                if (mem_ack) begin
                    state_d = (abort_q || ctrl_abort) ? StIdle : StWrite;
                end
            end
            StWrite: begin
                if (ctrl_abort) begin
                    state_d = StIdle;
                end else if (remaining_q == VRAM_W'(1)) begin
                    state_d = StDone;
                end else begin
                    state_d = StRead;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Register port, working pointers and captured read data
    always_ff @(posedge clk) begin
        if (!nreset) begin
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            src_ptr_q   <= '0;
            dst_ptr_q   <= '0;
            remaining_q <= '0;
            data_q      <= '0;
            abort_q     <= 1'b0;
        end else begin
            if ((state_q == StIdle) && cfg_we) begin
                case (cfg_addr)
                    2'd0:    src_q <= cfg_data[ADDR_W-1:0];
                    2'd1:    dst_q <= cfg_data[VRAM_W-1:0];
                    2'd2:    len_q <= cfg_data[VRAM_W-1:0];
                    default: ;
                endcase
            end
            if ((state_q == StIdle) && ctrl_start) begin
                src_ptr_q   <= src_q;
                dst_ptr_q   <= dst_q;
                remaining_q <= len_q;
            end
            if ((state_q == StRead) && mem_ack) begin
                data_q <= mem_q;
            end
            if (state_q == StWrite) begin
                src_ptr_q   <= src_ptr_q + 1'b1;
                dst_ptr_q   <= dst_ptr_q + 1'b1;
                remaining_q <= remaining_q - 1'b1;
            end
            abort_q <= abort_d;
        end
    end

    // Moore outputs decoded from the state
    always_comb begin
        mem_req   = (state_q == StRead);
        vram32_we = (state_q == StWrite);
        busy      = (state_q != StIdle);
        done_irq  = (state_q == StDone);
    end

    assign mem_addr     = src_ptr_q;
    assign vram32_waddr = dst_ptr_q;
    assign vram32_d     = data_q;
    assign remaining    = remaining_q;

endmodule

// File: tb/tb_vram_dma.sv
// Self-checking bench for vram_dma: directed scenarios plus randomized copies
// checked against a queue of expected VRAM writes built from SRC/DST/LEN.
module tb_vram_dma;

    localparam int unsigned ADDR_W = 27;
    localparam int unsigned VRAM_W = 14;

    logic              clk = 1'b0;
    logic              nreset;
    logic              cfg_we;
    logic [1:0]        cfg_addr;
    logic [31:0]       cfg_data;
    logic              frameDrawn;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack = 1'b0;
    logic [31:0]       mem_q = 32'h0;
    logic              vram32_we;
    logic [VRAM_W-1:0] vram32_waddr;
    logic [31:0]       vram32_d;
    logic              busy;
    logic [VRAM_W-1:0] remaining;
    logic              done_irq;

    always #5 clk = ~clk;

    vram_dma #(
        .ADDR_W(ADDR_W),
        .VRAM_W(VRAM_W)
    ) dut (
        .clk          (clk),
        .nreset       (nreset),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .frameDrawn   (frameDrawn),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_q        (mem_q),
        .vram32_we    (vram32_we),
        .vram32_waddr (vram32_waddr),
        .vram32_d     (vram32_d),
        .busy         (busy),
        .remaining    (remaining),
        .done_irq     (done_irq)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory model: word at address a is a ^ salt; ack after cur_lat wait cycles
    logic [31:0] salt = 32'h0;
    int fix_lat  = 0;
    int cur_lat  = 0;
    int wait_cnt = 0;

    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
        return 32'(a) ^ salt;
    endfunction

    task automatic set_lat(input int l);
        fix_lat = l;
        cur_lat = (l < 0) ? int'($urandom_range(0, 3)) : l;
    endtask

    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (!nreset || !mem_req) begin
            wait_cnt = 0;
        end else if (wait_cnt >= cur_lat) begin
            mem_ack  = 1'b1;
            mem_q    = mem_word(mem_addr);
            wait_cnt = 0;
            cur_lat  = (fix_lat < 0) ? int'($urandom_range(0, 3)) : fix_lat;
        end else begin
            wait_cnt++;
        end
    end

    // Scoreboard and event logs, sampled 1 time unit after each rising edge
    typedef struct packed {
        logic [VRAM_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    wr_t  exp_q[$];
    int   we_cyc[$];
    int   we_rem[$];
    int   done_cyc[$];
    int   req_rise[$];
    int   n_req = 0;
    logic req_prev = 1'b0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin : monitor
        wr_t e;
        #1;
        if (mem_req) n_req++;
        if (mem_req && !req_prev) req_rise.push_back(cyc);
        req_prev = mem_req;
        if (done_irq) done_cyc.push_back(cyc);
        if (vram32_we) begin
            we_cyc.push_back(cyc);
            we_rem.push_back(int'(remaining));
            check_eq("we_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("we_addr", vram32_waddr, e.a);
                check_eq("we_data", vram32_d, e.d);
            end
        end
    end

    task automatic clear_logs();
        exp_q.delete();
        we_cyc.delete();
        we_rem.delete();
        done_cyc.delete();
        req_rise.delete();
        n_req = 0;
    endtask

    task automatic push_exp(input logic [ADDR_W-1:0] src, input logic [VRAM_W-1:0] dst,
                            input int len);
        for (int i = 0; i < len; i++) begin
            wr_t e;
            e.a = dst + VRAM_W'(i);
            e.d = mem_word(src + ADDR_W'(i));
            exp_q.push_back(e);
        end
    endtask

    // Called at a falling edge; the write is sampled at the next rising edge
    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, busy, 1'b0);
    endtask

    int                t0;
    int                fd;
    int                n;
    logic [31:0]       v;
    logic [ADDR_W-1:0] m_src;
    logic [VRAM_W-1:0] m_dst;
    logic [VRAM_W-1:0] m_len;
    logic [ADDR_W-1:0] r_src;
    logic              sync;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nreset     = 1'b0;
        cfg_we     = 1'b0;
        cfg_addr   = 2'd0;
        cfg_data   = 32'h0;
        frameDrawn = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check_eq("rst_ctrl_outs", {mem_req, vram32_we, busy, done_irq}, 4'b0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_waddr", vram32_waddr, 0);
        check_eq("rst_wdata", vram32_d, 0);
        check_eq("rst_remaining", remaining, 0);
        nreset = 1'b1;
        @(negedge clk);

        // Immediate start, zero-wait memory, data equals address
        set_lat(0);
        salt = 32'h0;
        clear_logs();
        cfg_write(2'd0, 32'h100);
        cfg_write(2'd1, 32'h10);
        cfg_write(2'd2, 32'd4);
        push_exp(27'h100, 14'h10, 4);
        t0 = cyc;
        cfg_write(2'd3, 32'h1);
        wait_idle(50, "t1_timeout");
        check_eq("t1_busy_fall", cyc - t0, 10);
        check_eq("t1_n_we", we_cyc.size(), 4);
        for (int i = 0; i < we_cyc.size() && i < 4; i++) begin
            check_eq("t1_we_cycle", we_cyc[i] - t0, 2 * (i + 1));
        end
        check_eq("t1_n_done", done_cyc.size(), 1);
        if (done_cyc.size() > 0) check_eq("t1_done_cycle", done_cyc[0] - t0, 9);
        check_eq("t1_sb_empty", exp_q.size(), 0);
        check_eq("t1_remaining", remaining, 0);

        // A frame event while idle must not start anything
        clear_logs();
        frameDrawn = 1'b1;
        repeat (4) @(negedge clk);
        frameDrawn = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("t2_idle_evt", n_req, 0);

        // Frame-synchronised start, LEN=2
        set_lat(-1);
        salt  = $urandom;
        m_src = ADDR_W'($urandom);
        m_dst = VRAM_W'($urandom);
        cfg_write(2'd0, 32'(m_src));
        cfg_write(2'd1, 32'(m_dst));
        cfg_write(2'd2, 32'd2);
        push_exp(m_src, m_dst, 2);
        cfg_write(2'd3, 32'h3);
        repeat (6) @(negedge clk);
        check_eq("t2_no_req_before_frame", n_req, 0);
        fd = cyc;
        frameDrawn = 1'b1;
        wait_idle(60, "t2_timeout");
        check_eq("t2_n_rise", req_rise.size() >= 1, 1);
        if (req_rise.size() > 0) check_eq("t2_req_latency", req_rise[0] - fd, 4);
        check_eq("t2_n_we", we_cyc.size(), 2);
        check_eq("t2_n_done", done_cyc.size(), 1);
        check_eq("t2_sb_empty", exp_q.size(), 0);
        frameDrawn = 1'b0;
        repeat (4) @(negedge clk);

        // Zero-length transfer
        clear_logs();
        cfg_write(2'd2, 32'd0);
        t0 = cyc;
        cfg_write(2'd3, 32'h1);
        wait_idle(20, "t3_timeout");
        check_eq("t3_no_req", n_req, 0);
        check_eq("t3_no_we", we_cyc.size(), 0);
        check_eq("t3_n_done", done_cyc.size(), 1);
        if (done_cyc.size() > 0) check_eq("t3_done_cycle", done_cyc[0] - t0, 1);

        // Destination wraps from the top of VRAM32 to 0
        clear_logs();
        set_lat(-1);
        m_src = ADDR_W'($urandom);
        cfg_write(2'd0, 32'(m_src));
        cfg_write(2'd1, 32'h3FFF);
        cfg_write(2'd2, 32'd2);
        push_exp(m_src, 14'h3FFF, 2);
        cfg_write(2'd3, 32'h1);
        wait_idle(40, "t4_timeout");
        check_eq("t4_n_we", we_rem.size(), 2);
        if (we_rem.size() == 2) begin
            check_eq("t4_rem_first", we_rem[0], 2);
            check_eq("t4_rem_second", we_rem[1], 1);
        end
        check_eq("t4_rem_end", remaining, 0);
        check_eq("t4_sb_empty", exp_q.size(), 0);

        // Abort while a slow request is outstanding
        clear_logs();
        set_lat(5);
        cfg_write(2'd2, 32'd3);
        cfg_write(2'd3, 32'h1);
        @(negedge clk);
        cfg_write(2'd3, 32'h4);
        wait_idle(40, "t5_timeout");
        repeat (3) @(negedge clk);
        check_eq("t5_req_held", n_req, 6);
        check_eq("t5_one_request", req_rise.size(), 1);
        check_eq("t5_no_we", we_cyc.size(), 0);
        check_eq("t5_no_done", done_cyc.size(), 0);
        check_eq("t5_residual", remaining, 3);

        // Reset in the middle of an 8-word transfer
        clear_logs();
        set_lat(0);
        m_src = ADDR_W'($urandom);
        m_dst = VRAM_W'($urandom);
        cfg_write(2'd0, 32'(m_src));
        cfg_write(2'd1, 32'(m_dst));
        cfg_write(2'd2, 32'd8);
        push_exp(m_src, m_dst, 8);
        cfg_write(2'd3, 32'h1);
        n = 0;
        while (we_cyc.size() < 2 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("t6_two_words", we_cyc.size(), 2);
        nreset = 1'b0;
        @(negedge clk);
        check_eq("t6_busy_after_rst", busy, 1'b0);
        check_eq("t6_req_after_rst", mem_req, 1'b0);
        check_eq("t6_rem_after_rst", remaining, 0);
        nreset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        // LEN cleared by reset: START goes straight to DONE
        clear_logs();
        t0 = cyc;
        cfg_write(2'd3, 32'h1);
        wait_idle(20, "t6_len0_timeout");
        check_eq("t6_len0_no_req", n_req, 0);
        check_eq("t6_len0_n_done", done_cyc.size(), 1);
        if (done_cyc.size() > 0) check_eq("t6_len0_done_cycle", done_cyc[0] - t0, 1);
        // SRC and DST cleared by reset: one word from address 0 to VRAM 0
        clear_logs();
        cfg_write(2'd2, 32'd1);
        push_exp('0, '0, 1);
        cfg_write(2'd3, 32'h1);
        wait_idle(40, "t6_restart_timeout");
        check_eq("t6_restart_n_we", we_cyc.size(), 1);
        check_eq("t6_restart_n_done", done_cyc.size(), 1);
        check_eq("t6_restart_sb_empty", exp_q.size(), 0);
        m_src = '0;
        m_dst = '0;
        m_len = VRAM_W'(1);

        // Randomized transfers; the model keeps its own copy of SRC/DST/LEN
        for (int it = 0; it < 24; it++) begin
            clear_logs();
            set_lat(-1);
            salt = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                v = $urandom;
                if ($urandom_range(0, 3) == 0) begin
                    r_src = '1;
                    r_src = r_src - ADDR_W'($urandom_range(0, 3));
                    v[ADDR_W-1:0] = r_src;
                end
                m_src = v[ADDR_W-1:0];
                cfg_write(2'd0, v);
            end
            if ($urandom_range(0, 1) == 1) begin
                v = $urandom;
                if ($urandom_range(0, 3) == 0) v[VRAM_W-1:0] = 14'h3FFE;
                m_dst = v[VRAM_W-1:0];
                cfg_write(2'd1, v);
            end
            if ($urandom_range(0, 1) == 1) begin
                v = $urandom;
                v[VRAM_W-1:0] = VRAM_W'($urandom_range(0, 6));
                m_len = v[VRAM_W-1:0];
                cfg_write(2'd2, v);
            end
            sync = 1'($urandom_range(0, 1));
            push_exp(m_src, m_dst, int'(m_len));
            v = $urandom;
            v[0] = 1'b1;
            v[1] = sync;
            cfg_write(2'd3, v);
            // Register writes while busy must be ignored
            if ($urandom_range(0, 1) == 1) cfg_write(2'($urandom_range(0, 2)), $urandom);
            if (sync) begin
                repeat ($urandom_range(1, 4)) @(negedge clk);
                frameDrawn = 1'b1;
            end
            wait_idle(200, "rnd_timeout");
            frameDrawn = 1'b0;
            repeat (4) @(negedge clk);
            check_eq("rnd_n_we", we_cyc.size(), int'(m_len));
            check_eq("rnd_n_done", done_cyc.size(), 1);
            check_eq("rnd_sb_empty", exp_q.size(), 0);
            check_eq("rnd_remaining", remaining, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
